biquad_cascade_ctrl: RTL and testbench
======================================

Name: biquad_cascade_ctrl

Overview:
- Sequencing and configuration controller for a chain of NUM_STAGES biquad_filter instances. The chain is stage 0 valid_out into stage 1 pcm_valid, and so on.
- Holds a shadow and an active coefficient bank. Active coefficients are committed atomically, only between samples, so no sample is computed with mixed coefficient sets.
- Gates incoming PCM strobes into stage 0, tracks chain occupancy, counts overruns, and recovers from a stalled chain with a watchdog.
- Sits between the I2S/PCM front end and the EQ cascade. Software or the UI FSM drives the cfg port.

Parameters:
- NUM_STAGES, 4, number of cascaded biquad sections (1..8).
- TIMEOUT, 256, maximum cycles in BUSY before forced return to IDLE (must exceed NUM_STAGES*14).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  write strobe for one shadow coefficient.
- cfg_stage  in  3  target stage index.
- cfg_sel  in  3  coefficient select: 0=B0, 1=B1, 2=B2, 3=A1, 4=A2.
- cfg_data  in  16  signed Q2.14 coefficient value.
- cfg_err  out  1  one-cycle pulse when a write is rejected.
- commit_req  in  1  request to copy shadow bank to active bank.
- commit_ack  out  1  one-cycle pulse on the cycle the copy is applied.
- sample_valid  in  1  one-cycle strobe: new PCM sample present at stage 0 d_in.
- stage0_valid  out  1  registered strobe to stage 0 pcm_valid.
- chain_done  in  1  valid_out of the last stage.
- coef_out  out  NUM_STAGES*80  active bank. Stage s occupies bits [s*80 +: 80], packed {A2,A1,B2,B1,B0}, B0 in the LSBs.
- busy  out  1  high while state==BUSY.
- overrun_cnt  out  16  count of dropped samples, saturating.
- timeout_pulse  out  1  one-cycle pulse on watchdog expiry.

Behaviour:
- Reset (async) sets every stage's shadow and active bank to passthrough: B0=16'sd16384 (1.0 in Q2.14), B1=B2=A1=A2=0. Reset also clears:
  - state to IDLE and commit_pending to 0
  - stage0_valid, commit_ack, cfg_err, timeout_pulse, busy to 0
  - overrun_cnt and the watchdog counter to 0
- Reset mid-operation aborts any in-flight sample and any pending commit. No ack is issued for an aborted commit.
- Shadow writes:
  - Accepted in any state when cfg_we=1, cfg_stage<NUM_STAGES and cfg_sel<=4. The shadow register updates at the next edge.
  - Out-of-range stage or sel: no write, and cfg_err pulses the following cycle.
- commit_req sets commit_pending. Further requests while pending merge, producing a single ack.
- States:
  - IDLE:
    - If commit_pending: active<=shadow for all stages, commit_pending<=0, commit_ack pulses next cycle.
    - If sample_valid: stage0_valid<=1 for exactly one cycle, watchdog<=0, state<=BUSY.
    - Both may occur on the same edge. The new coefficients are then in place before stage 0 reaches its first multiply.
    - chain_done in IDLE is ignored.
  - BUSY:
    - The watchdog increments each cycle.
    - chain_done: state<=IDLE at next edge.
    - Watchdog reaches TIMEOUT-1 without chain_done: state<=IDLE and timeout_pulse.
    - Commits stay pending until IDLE.
- Overrun: sample_valid while in BUSY is dropped and overrun_cnt increments, saturating at 16'hFFFF. This holds even when chain_done arrives on the same cycle.
- Write/commit collision: if cfg_we lands on the same edge as a commit copy, the copy takes the pre-write shadow value. The write still updates shadow, and a later commit delivers it.
- commit_req arriving while in IDLE with no sample gives commit_ack one cycle after commit_pending is seen. Latency is 2 cycles from commit_req.
- Latency from sample_valid to stage0_valid is 1 cycle.
- coef_out changes only on commit edges. busy is a registered decode of state.

Test Plan:
- Reset, read coef_out -> every stage has B0=16384 and others 0; overrun_cnt=0; all pulse outputs 0.
- Write stage1 B1=0x1234, then commit_req in IDLE -> commit_ack pulses 2 cycles after req; coef_out[80+16 +: 16]=0x1234; other fields unchanged.
- sample_valid, then commit_req while BUSY, then chain_done at cycle 60 -> no ack before chain_done; ack arrives 1 cycle after return to IDLE.
- Three sample_valid strobes while BUSY, one of them on the chain_done cycle -> overrun_cnt=3; stage0_valid pulsed only once.
- sample_valid with chain_done never asserted, TIMEOUT=256 -> timeout_pulse after 256 BUSY cycles; next sample_valid issues stage0_valid normally.
- Write with cfg_sel=5 and one with cfg_stage=NUM_STAGES -> cfg_err pulses each; after a commit, shadow and active banks are unchanged.

Source files
------------

// File: rtl/biquad_cascade_ctrl.sv
//==============================================================================
// Module      : biquad_cascade_ctrl
// Description : Sequencer and double-buffered coefficient store for a cascade
//               of biquad sections; gates PCM strobes, counts overruns and
//               recovers a stalled chain with a watchdog.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module biquad_cascade_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int TIMEOUT    = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_stage,
    input  logic [2:0]               cfg_sel,
    input  logic [15:0]              cfg_data,
    output logic                     cfg_err,
    input  logic                     commit_req,
    output logic                     commit_ack,
    input  logic                     sample_valid,
    output logic                     stage0_valid,
    input  logic                     chain_done,
    output logic [NUM_STAGES*80-1:0] coef_out,
    output logic                     busy,
    output logic [15:0]              overrun_cnt,
    output logic                     timeout_pulse
);

    localparam int BANK_W = NUM_STAGES * 80;
    localparam int WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    // {A2,A1,B2,B1,B0} with B0 = 1.0 in Q2.14
    localparam logic [79:0]       c_passthrough = {64'd0, 16'h4000};
    localparam logic [WD_W-1:0]   c_wd_last     = WD_W'(TIMEOUT - 1);
    localparam logic [15:0]       c_ovr_max     = 16'hFFFF;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [BANK_W-1:0]  shadow_q, shadow_d;
    logic [BANK_W-1:0]  active_q, active_d;
    logic               pending_q, pending_d;
    logic               stage0_valid_q, stage0_valid_d;
    logic               commit_ack_q, commit_ack_d;
    logic               cfg_err_q, cfg_err_d;
    logic               timeout_q, timeout_d;
    logic               busy_q, busy_d;
    logic [15:0]        overrun_q, overrun_d;
    logic [WD_W-1:0]    wd_q, wd_d;

    logic               w_stage_ok;
    logic               w_sel_ok;
    logic               w_wr_ok;

    //--------------------------------------------------------------------------
    // Shadow bank writes; a rejected write only raises cfg_err
    //--------------------------------------------------------------------------
    always_comb begin
        w_stage_ok = ({1'b0, cfg_stage} < 4'(NUM_STAGES));
        w_sel_ok   = (cfg_sel <= 3'd4);
        w_wr_ok    = cfg_we && w_stage_ok && w_sel_ok;
        cfg_err_d  = cfg_we && !(w_stage_ok && w_sel_ok);
        shadow_d   = shadow_q;
        for (int s = 0; s < NUM_STAGES; s++) begin
            for (int k = 0; k < 5; k++) begin
                if (w_wr_ok && (cfg_stage == 3'(s)) && (cfg_sel == 3'(k))) begin
                    shadow_d[s*80 + k*16 +: 16] = cfg_data;
                end
            end
        end
    end

    //--------------------------------------------------------------------------
    // Sequencer: commits are applied only in IDLE so a sample never sees a
    // mixed coefficient set; a request arriving on the copy edge re-arms.
    //--------------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        active_d       = active_q;
        pending_d      = pending_q | commit_req;
        commit_ack_d   = 1'b0;
        stage0_valid_d = 1'b0;
        timeout_d      = 1'b0;
        wd_d           = wd_q;
        overrun_d      = overrun_q;

        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    active_d     = shadow_q;
                    pending_d    = commit_req;
                    commit_ack_d = 1'b1;
                end
                if (sample_valid) begin
                    stage0_valid_d = 1'b1;
                    wd_d           = '0;
                    state_d        = BUSY;
                end
            end
            BUSY: begin
                if (sample_valid && (overrun_q != c_ovr_max)) begin
                    overrun_d = overrun_q + 16'd1;
                end
                if (chain_done) begin
                    state_d = IDLE;
                end else if (wd_q == c_wd_last) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == BUSY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            shadow_q       <= {NUM_STAGES{c_passthrough}};
            active_q       <= {NUM_STAGES{c_passthrough}};
            pending_q      <= 1'b0;
            stage0_valid_q <= 1'b0;
            commit_ack_q   <= 1'b0;
            cfg_err_q      <= 1'b0;
            timeout_q      <= 1'b0;
            busy_q         <= 1'b0;
            overrun_q      <= 16'd0;
            wd_q           <= '0;
        end else begin
            state_q        <= state_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            pending_q      <= pending_d;
            stage0_valid_q <= stage0_valid_d;
            commit_ack_q   <= commit_ack_d;
            cfg_err_q      <= cfg_err_d;
            timeout_q      <= timeout_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            wd_q           <= wd_d;
        end
    end

    assign cfg_err       = cfg_err_q;
    assign commit_ack    = commit_ack_q;
    assign stage0_valid  = stage0_valid_q;
    assign coef_out      = active_q;
    assign busy          = busy_q;
    assign overrun_cnt   = overrun_q;
    assign timeout_pulse = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_biquad_cascade_ctrl.sv
//==============================================================================
// Module      : tb_biquad_cascade_ctrl
// Description : Directed scoreboard bench for biquad_cascade_ctrl.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_biquad_cascade_ctrl;

    localparam int NS = 4;
    localparam int TO = 256;
    localparam int CW = NS * 80;

    typedef logic [CW-1:0] cw_t;

    logic          clk;
    logic          rst;
    logic          cfg_we;
    logic [2:0]    cfg_stage;
    logic [2:0]    cfg_sel;
    logic [15:0]   cfg_data;
    logic          cfg_err;
    logic          commit_req;
    logic          commit_ack;
    logic          sample_valid;
    logic          stage0_valid;
    logic          chain_done;
    logic [CW-1:0] coef_out;
    logic          busy;
    logic [15:0]   overrun_cnt;
    logic          timeout_pulse;

    biquad_cascade_ctrl #(
        .NUM_STAGES (NS),
        .TIMEOUT    (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_stage     (cfg_stage),
        .cfg_sel       (cfg_sel),
        .cfg_data      (cfg_data),
        .cfg_err       (cfg_err),
        .commit_req    (commit_req),
        .commit_ack    (commit_ack),
        .sample_valid  (sample_valid),
        .stage0_valid  (stage0_valid),
        .chain_done    (chain_done),
        .coef_out      (coef_out),
        .busy          (busy),
        .overrun_cnt   (overrun_cnt),
        .timeout_pulse (timeout_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_pass = 0;
    int   n_total = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_s0 = 0;
    int   n_ack = 0;
    int   last_ack_cyc = -1;
    int   s0q[$];
    cw_t  cq[$];
    cw_t  sh;
    cw_t  pass_bank;

    task automatic check(input string tag, input cw_t obs, input cw_t exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1 time unit later and retire scoreboard entries
    task automatic tick();
        int  e;
        cw_t ce;
        @(posedge clk);
        #1;
        cyc++;
        if (stage0_valid === 1'b1) begin
            n_s0++;
            check("s0_expected", cw_t'(s0q.size() != 0), cw_t'(1'b1));
            if (s0q.size() != 0) begin
                e = s0q.pop_front();
                check("s0_latency", cw_t'(cyc), cw_t'(e));
            end
        end
        if (commit_ack === 1'b1) begin
            n_ack++;
            last_ack_cyc = cyc;
            check("ack_expected", cw_t'(cq.size() != 0), cw_t'(1'b1));
            if (cq.size() != 0) begin
                ce = cq.pop_front();
                check("commit_coef", coef_out, ce);
            end
        end
    endtask

    task automatic wr(input int st, input int sl, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_stage = 3'(st);
        cfg_sel   = 3'(sl);
        cfg_data  = d;
        if (st < NS && sl <= 4) sh[st*80 + sl*16 +: 16] = d;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int c;
        int d;
        int sstart;
        int acks0;
        int s0base;
        int bcnt;
        logic [15:0] fld;

        rst = 1'b1; cfg_we = 1'b0; cfg_stage = 3'd0; cfg_sel = 3'd0;
        cfg_data = 16'd0; commit_req = 1'b0; sample_valid = 1'b0; chain_done = 1'b0;
        pass_bank = {NS{80'h4000}};
        sh = pass_bank;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_coef", coef_out, pass_bank);
        check("rst_overrun", cw_t'(overrun_cnt), cw_t'(16'd0));
        check("rst_s0", cw_t'(stage0_valid), cw_t'(1'b0));
        check("rst_ack", cw_t'(commit_ack), cw_t'(1'b0));
        check("rst_cfg_err", cw_t'(cfg_err), cw_t'(1'b0));
        check("rst_timeout", cw_t'(timeout_pulse), cw_t'(1'b0));
        check("rst_busy", cw_t'(busy), cw_t'(1'b0));

        // Simple write + commit in IDLE
        wr(1, 1, 16'h1234);
        check("valid_write_no_err", cw_t'(cfg_err), cw_t'(1'b0));
        check("write_not_active", coef_out, pass_bank);
        commit_req = 1'b1; c = cyc; cq.push_back(sh);
        tick();
        commit_req = 1'b0;
        check("ack_not_early", cw_t'(commit_ack), cw_t'(1'b0));
        tick();
        check("ack_latency", cw_t'(last_ack_cyc), cw_t'(c + 2));
        fld = coef_out[96 +: 16];
        check("stage1_b1", cw_t'(fld), cw_t'(16'h1234));
        tick();
        check("ack_one_cycle", cw_t'(commit_ack), cw_t'(1'b0));

        // Write landing on the commit copy edge: copy sees pre-write shadow
        commit_req = 1'b1; c = cyc; cq.push_back(sh);
        tick();
        commit_req = 1'b0;
        wr(3, 3, 16'h0F0F);
        check("collision_ack", cw_t'(last_ack_cyc), cw_t'(c + 2));
        fld = coef_out[3*80 + 48 +: 16];
        check("collision_pre_write", cw_t'(fld), cw_t'(16'h0000));

        // Commit requested while BUSY waits for IDLE
        sample_valid = 1'b1; s0q.push_back(cyc + 1); sstart = cyc;
        tick();
        sample_valid = 1'b0;
        check("busy_after_sample", cw_t'(busy), cw_t'(1'b1));
        wr(2, 4, 16'hBEEF);
        commit_req = 1'b1; cq.push_back(sh);
        tick();
        commit_req = 1'b0;
        acks0 = n_ack;
        while (cyc < sstart + 60) tick();
        check("no_ack_while_busy", cw_t'(n_ack), cw_t'(acks0));
        chain_done = 1'b1;
        tick();
        chain_done = 1'b0;
        d = cyc;
        check("idle_after_done", cw_t'(busy), cw_t'(1'b0));
        check("no_ack_at_done", cw_t'(n_ack), cw_t'(acks0));
        tick();
        check("ack_after_idle", cw_t'(last_ack_cyc), cw_t'(d + 1));

        // Overruns, one coinciding with chain_done
        s0base = n_s0;
        sample_valid = 1'b1; s0q.push_back(cyc + 1);
        tick();
        tick();
        sample_valid = 1'b0;
        repeat (3) tick();
        sample_valid = 1'b1;
        tick();
        chain_done = 1'b1;
        tick();
        sample_valid = 1'b0; chain_done = 1'b0;
        check("overrun_cnt", cw_t'(overrun_cnt), cw_t'(16'd3));
        check("idle_after_overrun", cw_t'(busy), cw_t'(1'b0));
        tick();
        check("s0_once", cw_t'(n_s0 - s0base), cw_t'(1));

        // Watchdog expiry
        sample_valid = 1'b1; s0q.push_back(cyc + 1);
        tick();
        sample_valid = 1'b0;
        bcnt = 0;
        while (busy === 1'b1 && bcnt < 400) begin
            bcnt++;
            tick();
        end
        check("busy_cycles", cw_t'(bcnt), cw_t'(TO));
        check("timeout_pulse", cw_t'(timeout_pulse), cw_t'(1'b1));
        check("overrun_hold", cw_t'(overrun_cnt), cw_t'(16'd3));
        tick();
        check("timeout_one_cycle", cw_t'(timeout_pulse), cw_t'(1'b0));
        sample_valid = 1'b1; s0q.push_back(cyc + 1);
        tick();
        sample_valid = 1'b0;
        check("busy_after_timeout", cw_t'(busy), cw_t'(1'b1));
        chain_done = 1'b1;
        tick();
        chain_done = 1'b0;

        // Rejected writes
        wr(0, 5, 16'h7777);
        check("err_bad_sel", cw_t'(cfg_err), cw_t'(1'b1));
        tick();
        check("err_clear", cw_t'(cfg_err), cw_t'(1'b0));
        wr(NS, 0, 16'h5555);
        check("err_bad_stage", cw_t'(cfg_err), cw_t'(1'b1));
        tick();
        commit_req = 1'b1; cq.push_back(sh);
        tick();
        commit_req = 1'b0;
        tick();
        check("err_bank_unchanged", coef_out, sh);

        // Asynchronous reset mid-sample with a commit pending
        sample_valid = 1'b1; s0q.push_back(cyc + 1);
        tick();
        sample_valid = 1'b0;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        acks0 = n_ack;
        #3 rst = 1'b1;
        #1;
        check("arst_busy", cw_t'(busy), cw_t'(1'b0));
        check("arst_coef", coef_out, pass_bank);
        check("arst_overrun", cw_t'(overrun_cnt), cw_t'(16'd0));
        cq.delete();
        sh = pass_bank;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        check("arst_no_ack", cw_t'(n_ack), cw_t'(acks0));
        check("s0q_drained", cw_t'(s0q.size()), cw_t'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
